// File: rtl/vud_seg_display.sv
// Sequential double-dabble binary-to-BCD converter driving a 4-digit multiplexed
// active-low 7-segment display; bcd updates idx_upper_bound+3 edges after capture.
module vud_seg_display #(
  parameter int idx_upper_bound = 9,
  parameter int SCAN_DIV        = 50000,
  parameter bit BLANK_LZ        = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [idx_upper_bound:0] value,
  output logic [15:0]              bcd,
  output logic                     busy,
  output logic [3:0]               an,
  output logic [6:0]               seg
);

  localparam int W  = idx_upper_bound + 1;
  localparam int CW = $clog2(W + 1);
  localparam int PW = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [W-1:0]    r_last;
  logic [W-1:0]    r_cap;
  logic [W-1:0]    r_shreg;
  logic [15:0]     r_work;
  logic [15:0]     w_adj;
  logic [CW-1:0]   r_cnt;
  logic [15:0]     r_bcd;

  logic [PW-1:0]   r_pre;
  logic [1:0]      r_idx;
  logic [1:0]      w_idx_nxt;
  logic [3:0]      r_an;
  logic [6:0]      r_seg;
  logic [3:0]      w_nib;
  logic            w_lz;
  logic [6:0]      w_seg;
  logic            w_tick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // SHIFT lingers one extra cycle with count 0 before handing off to LATCH.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (value != r_last) w_state_nxt = S_SHIFT;
      S_SHIFT: if (r_cnt == '0)     w_state_nxt = S_LATCH;
      S_LATCH: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_adj = r_work;
    for (int i = 0; i < 4; i++) begin
      if (r_work[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_work[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last  <= '0;
      r_cap   <= '0;
      r_shreg <= '0;
      r_work  <= '0;
      r_cnt   <= '0;
      r_bcd   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (value != r_last) begin
            r_cap   <= value;
            r_shreg <= value;
            r_work  <= '0;
            r_cnt   <= CW'(W);
          end
        end
        S_SHIFT: begin
          if (r_cnt != '0) begin
            r_work  <= 16'({w_adj, r_shreg[W-1]});
            r_shreg <= r_shreg << 1;
            r_cnt   <= r_cnt - CW'(1);
          end
        end
        S_LATCH: begin
          r_bcd  <= r_work;
          r_last <= r_cap;
        end
        default: ;
      endcase
    end
  end

  assign w_tick    = (r_pre == PW'(SCAN_DIV - 1));
  assign w_idx_nxt = r_idx + 2'd1;
  assign w_nib     = r_bcd[4*w_idx_nxt +: 4];

  // A digit is a leading zero when it and every more significant digit are zero.
  always_comb begin
    w_lz = 1'b0;
    case (w_idx_nxt)
      2'd1:    w_lz = (r_bcd[15:4]  == 12'd0);
      2'd2:    w_lz = (r_bcd[15:8]  == 8'd0);
      2'd3:    w_lz = (r_bcd[15:12] == 4'd0);
      default: w_lz = 1'b0;
    endcase
  end

  always_comb begin
    w_seg = 7'b1111111;
    if (!(BLANK_LZ && w_lz)) begin
      case (w_nib)
        4'd0:    w_seg = 7'b1000000;
        4'd1:    w_seg = 7'b1111001;
        4'd2:    w_seg = 7'b0100100;
        4'd3:    w_seg = 7'b0110000;
        4'd4:    w_seg = 7'b0011001;
        4'd5:    w_seg = 7'b0010010;
        4'd6:    w_seg = 7'b0000010;
        4'd7:    w_seg = 7'b1111000;
        4'd8:    w_seg = 7'b0000000;
        4'd9:    w_seg = 7'b0010000;
        default: w_seg = 7'b1111111;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre <= '0;
      r_idx <= 2'd3;
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
    end else if (w_tick) begin
      r_pre <= '0;
      r_idx <= w_idx_nxt;
      r_an  <= ~(4'b0001 << w_idx_nxt);
      r_seg <= w_seg;
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

  assign bcd  = r_bcd;
  assign busy = (r_state != S_IDLE);
  assign an   = r_an;
  assign seg  = r_seg;

endmodule

// File: tb/tb_vud_seg_display.sv
// Bench for vud_seg_display: two instances (leading-zero blanking on/off) checked
// every cycle against an arithmetic model, plus directed literal expectations.
module tb_vud_seg_display;

  localparam int SD   = 4;
  localparam int CONV = 12;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic [9:0]  value = '0;

  logic [15:0] bcd1, bcd0;
  logic        busy1, busy0;
  logic [3:0]  an1, an0;
  logic [6:0]  seg1, seg0;

  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;

  logic [6:0] segtab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  always #5 clk = ~clk;

  vud_seg_display #(.idx_upper_bound(9), .SCAN_DIV(SD), .BLANK_LZ(1'b1)) u_dut_lz (
    .clk(clk), .rst(rst), .value(value), .bcd(bcd1), .busy(busy1), .an(an1), .seg(seg1));

  vud_seg_display #(.idx_upper_bound(9), .SCAN_DIV(SD), .BLANK_LZ(1'b0)) u_dut_nz (
    .clk(clk), .rst(rst), .value(value), .bcd(bcd0), .busy(busy0), .an(an0), .seg(seg0));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] enc(input logic [15:0] b, input int i, input bit lz);
    int up;
    int d;
    up = int'(b) >> (4 * i);
    d  = up % 16;
    if (lz && i >= 1 && up == 0) return 7'b1111111;
    if (d > 9) return 7'b1111111;
    return segtab[d];
  endfunction

  // Model: a conversion is a fixed-length busy window after which bcd jumps to
  // the decimal digits of the captured value; the scan advances every SD cycles.
  int          m_last = 0;
  int          m_cap  = 0;
  int          m_left = 0;
  int          m_pre  = 0;
  int          m_idx  = 3;
  logic [15:0] m_bcd  = '0;
  logic [3:0]  m_an   = 4'b1111;
  logic [6:0]  m_seg1 = 7'b1111111;
  logic [6:0]  m_seg0 = 7'b1111111;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_last = 0; m_cap = 0; m_left = 0; m_bcd = '0;
      m_pre = 0; m_idx = 3; m_an = 4'b1111; m_seg1 = 7'b1111111; m_seg0 = 7'b1111111;
    end else begin
      if (m_pre == SD - 1) begin
        m_pre  = 0;
        m_idx  = (m_idx + 1) % 4;
        m_an   = ~(4'b0001 << m_idx);
        m_seg1 = enc(m_bcd, m_idx, 1'b1);
        m_seg0 = enc(m_bcd, m_idx, 1'b0);
      end else begin
        m_pre++;
      end
      if (m_left == 0) begin
        if (int'(value) != m_last) begin
          m_cap  = int'(value);
          m_left = CONV;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_bcd  = to_bcd(m_cap);
          m_last = m_cap;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_busy_lz", busy1, m_left != 0);
      chk("cyc_busy_nz", busy0, m_left != 0);
      chk("cyc_bcd_lz", bcd1, m_bcd);
      chk("cyc_bcd_nz", bcd0, m_bcd);
      chk("cyc_an_lz", an1, m_an);
      chk("cyc_an_nz", an0, m_an);
      chk("cyc_seg_lz", seg1, m_seg1);
      chk("cyc_seg_nz", seg0, m_seg0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input logic lvl, input string nm);
    int n;
    n = 0;
    while (busy1 !== lvl && n < 60) begin step(1); n++; end
    chk(nm, busy1, lvl);
  endtask

  task automatic wait_an(input logic [3:0] exp, input string nm);
    int n;
    n = 0;
    while (an1 !== exp && n < 40) begin step(1); n++; end
    chk(nm, an1, exp);
  endtask

  logic [3:0] scan_an  [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
  logic [6:0] scan_seg [5] = '{7'b0110000, 7'b0100100, 7'b1000000, 7'b1111001, 7'b0110000};
  logic [6:0] lz_seg1  [4] = '{7'b1111000, 7'b1111111, 7'b1111111, 7'b1111111};
  logic [6:0] lz_seg0  [4] = '{7'b1111000, 7'b1000000, 7'b1000000, 7'b1000000};

  initial begin
    int n;
    step(2);
    cmp_en = 1'b1;
    chk("rst_an", an1, 4'b1111);
    chk("rst_seg", seg1, 7'b1111111);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_bcd", bcd1, 16'h0000);

    rst = 1'b1;
    step(2);
    chk("pre_tick_an", an1, 4'b1111);
    chk("pre_tick_seg", seg1, 7'b1111111);
    step(20);
    chk("idle_busy", busy1, 1'b0);
    chk("idle_bcd", bcd1, 16'h0000);

    value = 10'd1023;
    wait_busy(1'b1, "busy_rise_1023");
    n = 0;
    while (busy1 === 1'b1 && n < 40) begin step(1); n++; end
    chk("busy_len_1023", n, CONV);
    chk("bcd_1023", bcd1, 16'h1023);
    chk("model_1023", m_bcd, 16'h1023);

    wait_an(4'b1110, "scan_sync_1023");
    for (int k = 0; k < 5; k++) begin
      if (k > 0) step(SD);
      chk("scan_an", an1, scan_an[k]);
      chk("scan_seg_lz", seg1, scan_seg[k]);
      chk("scan_seg_nz", seg0, scan_seg[k]);
    end

    value = 10'd7;
    step(20);
    chk("bcd_7", bcd1, 16'h0007);
    wait_an(4'b1110, "scan_sync_7");
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step(SD);
      chk("lz_seg_on", seg1, lz_seg1[k]);
      chk("lz_seg_off", seg0, lz_seg0[k]);
    end

    value = 10'd500;
    wait_busy(1'b1, "busy_rise_500");
    step(4);
    value = 10'd999;
    n = 0;
    while (bcd1 === 16'h0007 && n < 40) begin step(1); n++; end
    chk("bcd_500", bcd1, 16'h0500);
    wait_busy(1'b1, "busy_rise_999");
    n = 0;
    while (bcd1 !== 16'h0999 && n < 40) begin
      if (bcd1 !== 16'h0500) chk("no_partial", bcd1, 16'h0500);
      step(1);
      n++;
    end
    chk("lat_999", n, CONV);
    chk("bcd_999", bcd1, 16'h0999);

    value = 10'd1000;
    wait_busy(1'b1, "busy_rise_1000");
    step(3);
    rst = 1'b0;
    #1;
    chk("abort_bcd", bcd1, 16'h0000);
    chk("abort_busy", busy1, 1'b0);
    chk("abort_an", an1, 4'b1111);
    step(2);
    rst = 1'b1;
    wait_busy(1'b1, "busy_rise_restart");
    wait_busy(1'b0, "busy_fall_restart");
    chk("bcd_1000", bcd1, 16'h1000);
    step(5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
